// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, default widths and a counter-width helper for the
// PLL configuration controller.
package pll_ctrl_pkg;

  localparam int DEF_REF_DIV_WIDTH = 4;
  localparam int DEF_FB_DIV_WIDTH  = 8;

  typedef enum logic [1:0] {
    ASSERT_RST,
    WAIT_LOCK,
    LOCKED,
    ERROR
  } pll_ctrl_state_e;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module pll_lock_sync (
  input  logic clk_i,
  input  logic arst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      meta_q <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_o <= meta_q;
    end
  end

endmodule

// File: rtl/pll_cfg_ctrl.sv
// PLL reset/divider sequencer with debounced lock, timeout retries and clock gating.
// Define PLL_CTRL_RANGE_CHECK_EN to reject requests carrying a zero divider.
module pll_cfg_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int REF_DEV_WIDTH = DEF_REF_DIV_WIDTH,
  parameter int FB_DIV_WIDTH  = DEF_FB_DIV_WIDTH,
  parameter int DEF_REFDIV    = 1,
  parameter int DEF_FBDIV     = 1,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_STABLE   = 32,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int MAX_RETRY     = 3
) (
  input  logic                               clk_i,
  input  logic                               arst_i,
  input  logic                               cfg_valid_i,
  output logic                               cfg_ready_o,
  input  logic [REF_DEV_WIDTH-1:0]           cfg_refdiv_i,
  input  logic [FB_DIV_WIDTH-1:0]            cfg_fbdiv_i,
  output logic                               pll_arst_no,
  output logic [REF_DEV_WIDTH-1:0]           pll_refdiv_o,
  output logic [FB_DIV_WIDTH-1:0]            pll_fbdiv_o,
  input  logic                               pll_locked_i,
  output logic                               clk_en_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               err_o,
  output logic                               lock_lost_o,
  output logic [cnt_width(MAX_RETRY)-1:0]    retry_cnt_o
);

  localparam int RST_W    = cnt_width(RST_CYCLES);
  localparam int STABLE_W = cnt_width(LOCK_STABLE);
  localparam int TO_W     = cnt_width(LOCK_TIMEOUT);
  localparam int RTY_W    = cnt_width(MAX_RETRY);

  pll_ctrl_state_e     state;
  logic [RST_W-1:0]    rst_cnt;
  logic [STABLE_W-1:0] stable_cnt;
  logic [TO_W-1:0]     timeout_cnt;
  logic                lock_sync;

  pll_lock_sync u_lock_sync (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .async_i (pll_locked_i),
    .sync_o  (lock_sync)
  );

  assign cfg_ready_o = (state == LOCKED) || (state == ERROR);
  assign busy_o      = !cfg_ready_o;

  logic accept;
  logic req_bad;
  assign accept = cfg_valid_i && cfg_ready_o;

`ifdef PLL_CTRL_RANGE_CHECK_EN
  assign req_bad = (cfg_refdiv_i == '0) || (cfg_fbdiv_i == '0);
`else
  assign req_bad = 1'b0;
`endif

  // Next-cycle counter values; lock completion takes priority over timeout.
  logic [STABLE_W-1:0] stable_nxt;
  logic [TO_W-1:0]     timeout_nxt;
  logic                lock_done;
  logic                timeout_hit;
  assign stable_nxt  = lock_sync ? stable_cnt + STABLE_W'(1) : '0;
  assign timeout_nxt = timeout_cnt + TO_W'(1);
  assign lock_done   = lock_sync && (stable_nxt == STABLE_W'(LOCK_STABLE));
  assign timeout_hit = (timeout_nxt == TO_W'(LOCK_TIMEOUT));

  // NOTE: every state/output register below uses <= so all of them sample
  // pre-edge values; mixing in blocking writes would create order races.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= ASSERT_RST;
      pll_arst_no  <= 1'b0;
      pll_refdiv_o <= REF_DEV_WIDTH'(DEF_REFDIV);
      pll_fbdiv_o  <= FB_DIV_WIDTH'(DEF_FBDIV);
      clk_en_o     <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      lock_lost_o  <= 1'b0;
      retry_cnt_o  <= '0;
      rst_cnt      <= '0;
      stable_cnt   <= '0;
      timeout_cnt  <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (accept && req_bad) begin
        done_o <= 1'b1;
        err_o  <= 1'b1;
      end else if (accept) begin
        pll_refdiv_o <= cfg_refdiv_i;
        pll_fbdiv_o  <= cfg_fbdiv_i;
        lock_lost_o  <= 1'b0;
        retry_cnt_o  <= '0;
        clk_en_o     <= 1'b0;
        pll_arst_no  <= 1'b0;
        rst_cnt      <= '0;
        state        <= ASSERT_RST;
      end else begin
        unique case (state)
          ASSERT_RST: begin
            if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
              rst_cnt     <= '0;
              stable_cnt  <= '0;
              timeout_cnt <= '0;
              pll_arst_no <= 1'b1;
              state       <= WAIT_LOCK;
            end else begin
              rst_cnt <= rst_cnt + RST_W'(1);
            end
          end
          WAIT_LOCK: begin
            if (lock_done) begin
              stable_cnt  <= '0;
              timeout_cnt <= '0;
              done_o      <= 1'b1;
              state       <= LOCKED;
            end else if (timeout_hit) begin
              stable_cnt  <= '0;
              timeout_cnt <= '0;
              pll_arst_no <= 1'b0;
              if (retry_cnt_o < RTY_W'(MAX_RETRY)) begin
                retry_cnt_o <= retry_cnt_o + RTY_W'(1);
                rst_cnt     <= '0;
                state       <= ASSERT_RST;
              end else begin
                clk_en_o <= 1'b0;
                done_o   <= 1'b1;
                err_o    <= 1'b1;
                state    <= ERROR;
              end
            end else begin
              stable_cnt  <= stable_nxt;
              timeout_cnt <= timeout_nxt;
            end
          end
          LOCKED: begin
            // A lock drop re-qualifies lock without resetting the PLL.
            if (!lock_sync) begin
              lock_lost_o <= 1'b1;
              clk_en_o    <= 1'b0;
              retry_cnt_o <= '0;
              stable_cnt  <= '0;
              timeout_cnt <= '0;
              state       <= WAIT_LOCK;
            end else begin
              clk_en_o <= 1'b1;
            end
          end
          ERROR: begin
            pll_arst_no <= 1'b0;
            clk_en_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// Directed self-checking bench for pll_cfg_ctrl with a small behavioural PLL lock model.
module tb_pll_cfg_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int MAX_RETRY    = 2;
  localparam int LOCK_DLY     = 10;
  // Rise of pll_arst_no to done_o: model delay (first high sample counts as 1),
  // two synchronizer stages, then the stable count.
  localparam int BOOT_LAT     = (LOCK_DLY - 1) + 2 + LOCK_STABLE;
  localparam int RELOCK_LAT   = 2 + LOCK_STABLE;

  logic       clk_i = 1'b0;
  logic       arst_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [3:0] cfg_refdiv_i;
  logic [7:0] cfg_fbdiv_i;
  logic       pll_arst_no;
  logic [3:0] pll_refdiv_o;
  logic [7:0] pll_fbdiv_o;
  logic       pll_locked_i;
  logic       clk_en_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic       lock_lost_o;
  logic [1:0] retry_cnt_o;

  pll_cfg_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_refdiv_i (cfg_refdiv_i),
    .cfg_fbdiv_i  (cfg_fbdiv_i),
    .pll_arst_no  (pll_arst_no),
    .pll_refdiv_o (pll_refdiv_o),
    .pll_fbdiv_o  (pll_fbdiv_o),
    .pll_locked_i (pll_locked_i),
    .clk_en_o     (clk_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .lock_lost_o  (lock_lost_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // PLL lock model, evaluated on the falling edge.
  typedef enum {LK_NORMAL, LK_NEVER, LK_TOGGLE} lk_mode_e;
  lk_mode_e lk_mode    = LK_NORMAL;
  int       since      = 0;
  logic     model_lock = 1'b0;
  logic     force_low  = 1'b0;

  always @(negedge clk_i) begin
    if (pll_arst_no !== 1'b1) since = 0;
    else                      since = since + 1;
    case (lk_mode)
      LK_NORMAL: model_lock = (since >= LOCK_DLY);
      LK_NEVER:  model_lock = 1'b0;
      LK_TOGGLE: model_lock = (since > 0) && ((((since - 1) / 5) % 2) == 0);
      default:   model_lock = 1'b0;
    endcase
  end

  assign pll_locked_i = model_lock & ~force_low;

  int arst_rises = 0;
  always @(posedge pll_arst_no) arst_rises++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // Counts low samples of pll_arst_no starting with the current one.
  task automatic wait_arst_high(output int n);
    n = 0;
    while (pll_arst_no !== 1'b1 && n < 200) begin
      n++;
      cyc();
    end
  endtask

  // Counts cycles from the current (high) sample until pll_arst_no is low.
  task automatic wait_arst_low(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (pll_arst_no !== 1'b0 && n < 200);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (done_o !== 1'b1 && n < 200);
  endtask

  task automatic request(input logic [3:0] rdiv, input logic [7:0] fdiv);
    cfg_valid_i  = 1'b1;
    cfg_refdiv_i = rdiv;
    cfg_fbdiv_i  = fdiv;
    cyc();
    cfg_valid_i  = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises0;

    arst_i       = 1'b1;
    cfg_valid_i  = 1'b0;
    cfg_refdiv_i = '0;
    cfg_fbdiv_i  = '0;
    repeat (3) cyc();

    // Reset values
    check("rst_pll_arst_no", pll_arst_no, 0);
    check("rst_refdiv", pll_refdiv_o, 1);
    check("rst_fbdiv", pll_fbdiv_o, 1);
    check("rst_clk_en", clk_en_o, 0);
    check("rst_done_err", {done_o, err_o, lock_lost_o}, 0);
    check("rst_retry", retry_cnt_o, 0);
    check("rst_busy", busy_o, 1);
    check("rst_ready", cfg_ready_o, 0);

    // 1. Boot
    arst_i = 1'b0;
    wait_arst_high(n);
    check("boot_rst_len", n, RST_CYCLES);
    wait_done(n);
    check("boot_lock_lat", n, BOOT_LAT);
    check("boot_err", err_o, 0);
    check("boot_clk_en_early", clk_en_o, 0);
    cyc();
    check("boot_clk_en", clk_en_o, 1);
    check("boot_done_pulse", done_o, 0);
    check("boot_ready", cfg_ready_o, 1);
    check("boot_busy", busy_o, 0);

    // 2. Reconfigure
    check("rcfg_ready", cfg_ready_o, 1);
    request(4'd8, 8'd16);
    check("rcfg_refdiv", pll_refdiv_o, 8);
    check("rcfg_fbdiv", pll_fbdiv_o, 16);
    check("rcfg_clk_en", clk_en_o, 0);
    check("rcfg_busy", busy_o, 1);
    wait_arst_high(n);
    check("rcfg_rst_len", n, RST_CYCLES);
    wait_done(n);
    check("rcfg_lock_lat", n, BOOT_LAT);
    check("rcfg_err", err_o, 0);
    cyc();
    check("rcfg_clk_en_up", clk_en_o, 1);

    // 4. Lock glitch while LOCKED
    rises0    = arst_rises;
    force_low = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (lock_lost_o !== 1'b1 && n < 20);
    check("glitch_detect_lat", n, 3);
    check("glitch_clk_en", clk_en_o, 0);
    check("glitch_ready", cfg_ready_o, 0);
    force_low = 1'b0;
    wait_done(n);
    check("glitch_relock_lat", n, RELOCK_LAT);
    check("glitch_no_pll_rst", arst_rises - rises0, 0);
    check("glitch_pll_arst_no", pll_arst_no, 1);
    check("glitch_sticky", lock_lost_o, 1);
    cyc();
    check("glitch_clk_en_up", clk_en_o, 1);

    // 5. Toggling lock never debounces; timeout forces a retry
    lk_mode = LK_TOGGLE;
    request(4'd2, 8'd20);
    check("tog_lock_lost_clr", lock_lost_o, 0);
    wait_arst_high(n);
    check("tog_rst_len", n, RST_CYCLES);
    wait_arst_low(n);
    check("tog_timeout", n, LOCK_TIMEOUT);
    check("tog_retry", retry_cnt_o, 1);
    check("tog_no_done", done_o, 0);
    lk_mode = LK_NORMAL;
    wait_arst_high(n);
    check("tog_retry_rst_len", n, RST_CYCLES);
    wait_done(n);
    check("tog_relock_lat", n, BOOT_LAT);
    check("tog_retry_kept", retry_cnt_o, 1);
    cyc();

    // 3. Never-locking PLL
    lk_mode = LK_NEVER;
    rises0  = arst_rises;
    request(4'd3, 8'd30);
    check("nl_retry_clr", retry_cnt_o, 0);
    for (int i = 0; i < 3; i++) begin
      wait_arst_high(n);
      check($sformatf("nl_rst_len%0d", i), n, RST_CYCLES);
      wait_arst_low(n);
      check($sformatf("nl_timeout%0d", i), n, LOCK_TIMEOUT);
      if (i < 2) begin
        check($sformatf("nl_retry%0d", i), retry_cnt_o, i + 1);
        check($sformatf("nl_no_done%0d", i), done_o, 0);
      end
    end
    check("nl_done_err", {done_o, err_o}, 2'b11);
    check("nl_ready", cfg_ready_o, 1);
    check("nl_clk_en", clk_en_o, 0);
    check("nl_pulses", arst_rises - rises0, 3);
    check("nl_retry_final", retry_cnt_o, 2);
    cyc();
    check("nl_pulse_end", {done_o, err_o}, 2'b00);
    check("nl_hold_rst", pll_arst_no, 0);

    // 6. Zero-divider request from ERROR
    request(4'd4, 8'd0);
`ifdef PLL_CTRL_RANGE_CHECK_EN
    check("rc_done_err", {done_o, err_o}, 2'b11);
    check("rc_fbdiv_kept", pll_fbdiv_o, 30);
    check("rc_refdiv_kept", pll_refdiv_o, 3);
    check("rc_still_error", cfg_ready_o, 1);
    lk_mode = LK_NORMAL;
    request(4'd4, 8'd40);
    check("rc_fbdiv_ok", pll_fbdiv_o, 40);
`else
    check("zd_fbdiv_applied", pll_fbdiv_o, 0);
    check("zd_refdiv_applied", pll_refdiv_o, 4);
    check("zd_busy", busy_o, 1);
    check("zd_no_done", done_o, 0);
    lk_mode = LK_NORMAL;
`endif

    // 6. Reset in the middle of WAIT_LOCK
    wait_arst_high(n);
    check("mid_rst_len", n, RST_CYCLES);
    repeat (5) cyc();
    arst_i = 1'b1;
    #1;
    check("arst_pll_arst_no", pll_arst_no, 0);
    check("arst_refdiv", pll_refdiv_o, 1);
    check("arst_fbdiv", pll_fbdiv_o, 1);
    check("arst_busy", busy_o, 1);
    check("arst_flags", {clk_en_o, done_o, err_o, lock_lost_o}, 0);
    check("arst_retry", retry_cnt_o, 0);
    repeat (2) cyc();
    arst_i = 1'b0;
    wait_arst_high(n);
    check("reboot_rst_len", n, RST_CYCLES);
    wait_done(n);
    check("reboot_lock_lat", n, BOOT_LAT);
    check("reboot_err", err_o, 0);
    check("reboot_fbdiv", pll_fbdiv_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_cfg_ctrl.md
Name: pll_cfg_ctrl

Overview:
Sequencing controller for the team's behavioural/analog PLL. Accepts divider-reconfiguration requests over a valid/ready handshake and drives the PLL's active-low reset and divider inputs. Waits for a debounced lock, retries on timeout, and gates the downstream clock enable. Sits in the clock-management domain on a free-running clock, typically the PLL reference clock.

Parameters:
REF_DEV_WIDTH, 4, width of the reference divider.
FB_DIV_WIDTH, 8, width of the feedback divider.
DEF_REFDIV, 1, reference divider applied at boot.
DEF_FBDIV, 1, feedback divider applied at boot.
RST_CYCLES, 16, cycles the PLL reset is held low per attempt (>=1).
LOCK_STABLE, 32, consecutive synced-lock-high cycles required to declare lock (>=1).
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before an attempt fails (>LOCK_STABLE).
MAX_RETRY, 3, extra attempts after the first timeout.

Ports:
clk_i  in  1  controller clock
arst_i  in  1  asynchronous reset, active-high
cfg_valid_i  in  1  reconfiguration request valid
cfg_ready_o  out  1  request accepted when valid&ready
cfg_refdiv_i  in  REF_DEV_WIDTH  requested reference divider
cfg_fbdiv_i  in  FB_DIV_WIDTH  requested feedback divider
pll_arst_no  out  1  PLL reset, active-low
pll_refdiv_o  out  REF_DEV_WIDTH  divider to PLL, registered
pll_fbdiv_o  out  FB_DIV_WIDTH  divider to PLL, registered
pll_locked_i  in  1  raw PLL lock, asynchronous
clk_en_o  out  1  downstream clock enable
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse: sequence finished
err_o  out  1  qualifies done_o: sequence failed
lock_lost_o  out  1  sticky: lock dropped while LOCKED
retry_cnt_o  out  $clog2(MAX_RETRY+1)  retries used in the current sequence

Behaviour:
- Reset values:
  - state=ASSERT_RST, pll_arst_no=0.
  - Dividers = DEF_REFDIV/DEF_FBDIV.
  - clk_en_o, done_o, err_o, lock_lost_o = 0.
  - retry_cnt_o and all counters = 0.
  - busy_o=1.
- Asserting arst_i mid-operation aborts immediately to the reset values. After release, the boot sequence runs with the defaults.
- pll_locked_i passes through a 2-flop synchronizer. The FSM sees lock 2 cycles late.
- cfg_ready_o = (state==LOCKED || state==ERROR), combinational from state.
- On accept:
  - Divider inputs are registered the same edge.
  - lock_lost_o and retry_cnt_o are cleared.
  - clk_en_o goes 0 next cycle.
  - Next state is ASSERT_RST.
- ASSERT_RST:
  - pll_arst_no=0 for exactly RST_CYCLES cycles, then WAIT_LOCK.
  - pll_arst_no=1 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - The timeout counter increments every cycle.
  - The stable counter increments on synced lock=1 and clears on 0.
  - Stable reaching LOCK_STABLE -> LOCKED: done_o pulses, clk_en_o=1 from the next cycle.
  - Timeout reaching LOCK_TIMEOUT without lock -> retry or fail:
    - if retry_cnt<MAX_RETRY: increment retry_cnt, go to ASSERT_RST.
    - else: go to ERROR, done_o and err_o pulse together.
  - If lock completion and timeout occur in the same cycle, lock wins.
- LOCKED:
  - If synced lock=0: set lock_lost_o, clk_en_o=0 next cycle, clear retry_cnt, go to WAIT_LOCK (no PLL reset).
  - If an accept occurs in the same cycle as a lock drop, the accept wins and lock_lost_o is not set.
- ERROR:
  - pll_arst_no=0, clk_en_o=0.
  - Remains until a new request or reset.
- busy_o = !(state==LOCKED || state==ERROR).
- Boot completion also pulses done_o.
- Counter widths: $clog2(param+1). Terminal comparisons use the parameter cast to counter width; counters never wrap.

Optional Feature:
PLL_CTRL_RANGE_CHECK_EN
- Defined: an accepted request with cfg_refdiv_i==0 or cfg_fbdiv_i==0 is rejected.
  - State and PLL outputs are unchanged.
  - lock_lost_o is not cleared.
  - done_o and err_o pulse together on the next cycle.
- Undefined: zero dividers are applied as-is, and the PLL simply fails to lock, giving the timeout/ERROR path.

Decomposition:
- Package pll_ctrl_pkg:
  - pll_ctrl_state_e enum: ASSERT_RST, WAIT_LOCK, LOCKED, ERROR.
  - Default width localparams.
- One sub-module, pll_lock_sync: 2-flop synchronizer with async active-high reset to 0, instantiated for pll_locked_i.

Test Plan:
Common parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, MAX_RETRY=2.
1. Boot: release arst_i, model locks 10 cycles after pll_arst_no rises.
   - pll_arst_no low exactly 4 cycles.
   - done_o=1, err_o=0 once 8 synced-high cycles have been counted.
   - clk_en_o=1 the following cycle.
2. Reconfigure from LOCKED with refdiv=8, fbdiv=16:
   - cfg_ready_o=1, outputs update next edge.
   - clk_en_o drops.
   - 4-cycle reset, relock, done_o.
3. Never-locking PLL:
   - Exactly 3 reset pulses of 4 cycles.
   - retry_cnt_o steps 1, 2.
   - ERROR with done_o&err_o, cfg_ready_o=1.
4. Lock glitch: lock low for 3 cycles while LOCKED.
   - lock_lost_o=1, clk_en_o=0.
   - No PLL reset, relock after 8 stable cycles.
   - Next accept clears lock_lost_o.
5. Lock toggling every 5 cycles in WAIT_LOCK:
   - Stable count never reaches 8.
   - Timeout at 64 cycles triggers a retry.
6. Reset mid-WAIT_LOCK, and the range-check request:
   - Reset: all outputs return to reset values and the defaults are reapplied.
   - With PLL_CTRL_RANGE_CHECK_EN, fbdiv=0 request gives done_o&err_o next cycle, pll_fbdiv_o unchanged.
